// File: rtl/seq_signed_divider_pkg.sv
// sdiv_pkg: shared state encoding and sizing for the sequential signed divider
package sdiv_pkg;
  typedef enum logic [1:0] {IDLE, DIVIDE, ZERO, FIX} state_t;
  localparam int DEF_N = 4;
  localparam int CNT_W = $clog2(2 * DEF_N + 1);
  function automatic int cnt_w(input int n);
    return $clog2(2 * n + 1);
  endfunction
endpackage

// File: rtl/seq_signed_divider_if.sv
// seq_signed_divider_if: start/done handshake and operand/result bus of the divider
interface seq_signed_divider_if #(parameter int N = 4);
  logic                  start;
  logic [2*N-1:0]        dividend;
  logic [N-1:0]          divisor;
  logic [2*N-1:0]        quotient;
  logic [N-1:0]          remainder;
  logic                  done;
  logic                  busy;
  logic                  div_by_zero;
  modport master (output start, dividend, divisor, input quotient, remainder, done, busy, div_by_zero);
  modport slave (input start, dividend, divisor, output quotient, remainder, done, busy, div_by_zero);
endinterface

// File: rtl/seq_signed_divider_sign_unit.sv
// sdiv_sign_unit: conditional two's-complement negation of a wide and a narrow lane
module sdiv_sign_unit #(
  parameter int WW = 8,
  parameter int NW = 5
) (
  input  logic [WW-1:0] i_wide,
  input  logic          i_wide_neg,
  input  logic [NW-1:0] i_narrow,
  input  logic          i_narrow_neg,
  output logic [WW-1:0] o_wide,
  output logic [NW-1:0] o_narrow
);
  // negate each lane when its flag is set; used both for abs() and for sign restore
  always_comb begin
    o_wide = i_wide_neg ? -i_wide : i_wide;
    o_narrow = i_narrow_neg ? -i_narrow : i_narrow;
  end
endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: radix-2 restoring signed divider, one quotient bit per clock
module seq_signed_divider
  import sdiv_pkg::*;
#(
  parameter int N = DEF_N
) (
  input logic clk,
  input logic rst,
  seq_signed_divider_if.slave bus
);
  localparam int W = 2 * N;
  localparam int CW = cnt_w(N);
  state_t r_state, w_next;
  logic r_sa, r_sb;
  logic [W-1:0] r_q;
  logic [N:0] r_d, r_p;
  logic [CW-1:0] r_cnt;
  logic [W-1:0] r_quo;
  logic [N-1:0] r_rem;
  logic r_done, r_busy, r_dbz;
  logic [W-1:0] w_abs_a, w_fix_q;
  logic [N:0] w_abs_b;
  logic [N-1:0] w_fix_r;
  logic [N+1:0] w_psh, w_diff;
  logic w_ok, w_last, w_go;
  logic [W-1:0] w_quo;
  logic [N-1:0] w_rem;
  logic w_done, w_busy, w_dbz;

  // divisor is sign-extended by one bit so |-2^(N-1)| is representable
  sdiv_sign_unit #(.WW(W), .NW(N + 1)) u_abs (
    .i_wide      (bus.dividend),
    .i_wide_neg  (bus.dividend[W-1]),
    .i_narrow    ({bus.divisor[N-1], bus.divisor}),
    .i_narrow_neg(bus.divisor[N-1]),
    .o_wide      (w_abs_a),
    .o_narrow    (w_abs_b)
  );

  // remainder magnitude is below |divisor|, so its low N bits suffice
  sdiv_sign_unit #(.WW(W), .NW(N)) u_fix (
    .i_wide      (r_q),
    .i_wide_neg  (r_sa ^ r_sb),
    .i_narrow    (r_p[N-1:0]),
    .i_narrow_neg(r_sa),
    .o_wide      (w_fix_q),
    .o_narrow    (w_fix_r)
  );

  assign w_go = (r_state == IDLE) && bus.start;
  assign w_psh = {r_p, r_q[W-1]};
  assign w_diff = w_psh - {1'b0, r_d};
  assign w_ok = !w_diff[N+1];
  assign w_last = r_cnt == CW'(W - 1);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  // next state: IDLE -> DIVIDE (2N iterations) -> FIX -> IDLE, or IDLE -> ZERO -> IDLE
  always_comb begin
    w_next = r_state == IDLE ? (bus.start ? (bus.divisor == '0 ? ZERO : DIVIDE) : IDLE)
           : r_state == DIVIDE ? (w_last ? FIX : DIVIDE)
           : IDLE;
  end

  // next values of the registered outputs; results hold between completions
  always_comb begin
    w_done = (r_state == FIX) || (r_state == ZERO);
    w_busy = w_next != IDLE;
    w_quo = r_state == FIX ? w_fix_q : r_state == ZERO ? '0 : r_quo;
    w_rem = r_state == FIX ? w_fix_r : r_state == ZERO ? '0 : r_rem;
    w_dbz = r_state == ZERO ? 1'b1 : r_state == FIX ? 1'b0 : r_dbz;
  end

  // operand capture on accept, then one shift/trial-subtract step per DIVIDE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa <= 1'b0;
      r_sb <= 1'b0;
      r_q <= '0;
      r_d <= '0;
      r_p <= '0;
      r_cnt <= '0;
    end else if (w_go) begin
      r_sa <= bus.dividend[W-1];
      r_sb <= bus.divisor[N-1];
      r_q <= w_abs_a;
      r_d <= w_abs_b;
      r_p <= '0;
      r_cnt <= '0;
    end else if (r_state == DIVIDE) begin
      r_p <= w_ok ? w_diff[N:0] : w_psh[N:0];
      r_q <= {r_q[W-2:0], w_ok};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
      r_dbz <= 1'b0;
    end else begin
      r_quo <= w_quo;
      r_rem <= w_rem;
      r_done <= w_done;
      r_busy <= w_busy;
      r_dbz <= w_dbz;
    end
  end

  assign bus.quotient = r_quo;
  assign bus.remainder = r_rem;
  assign bus.done = r_done;
  assign bus.busy = r_busy;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: directed and random checks against an integer-arithmetic reference
module tb_seq_signed_divider;
  localparam int N = 4;
  localparam int W = 2 * N;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  logic [W-1:0] eq;
  logic [N-1:0] er;
  logic ez;
  int elat;

  seq_signed_divider_if #(.N(N)) bus ();
  seq_signed_divider #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: language integer division truncates toward zero, % follows the dividend
  task automatic model(input int a, input int b);
    int q, r;
    if (b == 0) begin
      eq = '0; er = '0; ez = 1'b1; elat = 1;
    end else begin
      q = a / b;
      r = a % b;
      eq = W'(q); er = N'(r); ez = 1'b0; elat = W + 1;
    end
  endtask

  // pulse start for one edge, then scramble operands to prove they were latched
  task automatic launch(input int a, input int b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = W'(a);
    bus.divisor = N'(b);
    model(a, b);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor = N'($urandom);
  endtask

  task automatic await(input string tag, input int c0);
    int c;
    c = c0;
    while (!bus.done && c < 40) begin
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      c++;
    end
    chk({tag, " latency"}, 32'(c), 32'(elat));
    chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, " quotient"}, 32'(bus.quotient), 32'(eq));
    chk({tag, " remainder"}, 32'(bus.remainder), 32'(er));
    chk({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(ez));
  endtask

  initial begin
    int a, b, bad;
    logic signed [W-1:0] ra;
    logic signed [N-1:0] rb;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #12;
    chk("reset quotient", 32'(bus.quotient), 32'd0);
    chk("reset remainder", 32'(bus.remainder), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    launch(40, 5);
    await("40/5", 0);
    @(posedge clk);
    #1;
    chk("40/5 done_width", 32'(bus.done), 32'd0);
    chk("40/5 hold_quotient", 32'(bus.quotient), 32'd8);
    launch(-50, 7);
    await("-50/7", 0);
    launch(45, -6);
    await("45/-6", 0);
    launch(100, -8);
    await("100/-8", 0);
    launch(-128, -1);
    await("-128/-1", 0);
    launch(-128, 1);
    await("-128/1", 0);
    launch(127, -8);
    await("127/-8", 0);
    launch(37, 0);
    await("37/0", 0);
    launch(37, 4);
    await("37/4", 0);
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = N'($urandom);
      a = ra;
      b = rb;
      launch(a, b);
      await($sformatf("rnd%0d %0d/%0d", i, a, b), 0);
    end
    launch(100, 7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = W'(5);
    bus.divisor = N'(1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    await("repulse 100/7", 4);
    launch(90, 7);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst quotient", 32'(bus.quotient), 32'd0);
    chk("midrst remainder", 32'(bus.remainder), 32'd0);
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst done", 32'(bus.done), 32'd0);
    chk("midrst dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) bad++;
    end
    chk("midrst no_done", 32'(bad), 32'd0);
    launch(12, 3);
    await("12/3 after rst", 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
